cl_bank_sched: RTL and testbench

Ping-pong bank scheduler for the Camera Link capture path. It selects which of two frame memory banks (A=0, B=1) the line-capture datapath writes, and swaps banks on frame boundaries. It hands completed frames to one downstream reader (VGA out / pupil calculation) with a request/grant/done handshake. It sits between the camera sync inputs, the capture block's `iMEM_SEL`, and the consumer.

---
 rtl/cl_sched_pkg.sv | 25 ++
 rtl/cl_edge_det.sv | 33 +++
 rtl/cl_bank_sched.sv | 132 +++++++++++++
 tb/tb_cl_bank_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_sched_pkg.sv
// ---------------------------------------------------------------------------
// cl_sched_pkg : shared state encoding and bank constants for the bank scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package cl_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   function automatic logic other_bank(input logic bank);
      return (bank == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cl_edge_det.sv
// ---------------------------------------------------------------------------
// cl_edge_det : registered rise/fall pulse detector, one-cycle pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cl_edge_det (
   input  logic CCLK,
   input  logic RST,
   input  logic iSIG,
   output logic oRISE,
   output logic oFALL
);

   logic r_d;

   // Pulses are registered so downstream logic sees them one edge after the sample.
   always_ff @(posedge CCLK) begin
      if (RST) begin
         r_d   <= 1'b0;
         oRISE <= 1'b0;
         oFALL <= 1'b0;
      end else begin
         r_d   <= iSIG;
         oRISE <= iSIG & ~r_d;
         oFALL <= ~iSIG & r_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cl_bank_sched.sv
// ---------------------------------------------------------------------------
// cl_bank_sched : ping-pong frame bank scheduler with single-reader handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cl_bank_sched
   import cl_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int CNT_WIDTH  = 16,
   parameter int MIN_LINES  = 16
) (
   input  logic                  CCLK,
   input  logic                  RST,
   input  logic                  iEN,
   input  logic                  iVSYNC,
   input  logic                  iDE,
   input  logic                  iRD_REQ,
   input  logic                  iRD_DONE,
   output logic                  oMEM_SEL,
   output logic                  oWR_EN,
   output logic                  oFRAME_RDY,
   output logic                  oRD_GNT,
   output logic                  oRD_BANK,
   output logic [ADDR_WIDTH-1:0] oLINE_CNT,
   output logic [CNT_WIDTH-1:0]  oFRAME_CNT,
   output logic [CNT_WIDTH-1:0]  oDROP_CNT
);

   localparam logic [ADDR_WIDTH-1:0] c_min_lines = ADDR_WIDTH'(MIN_LINES);
   localparam logic [ADDR_WIDTH-1:0] c_line_one  = ADDR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  c_cnt_one   = CNT_WIDTH'(1);

   state_t                r_state;
   logic                  w_vs_rise;
   logic                  w_vs_fall;
   logic                  w_de_rise;
   logic                  w_de_fall;
   logic [ADDR_WIDTH-1:0] w_lines;
   logic                  w_frame_end;
   logic                  w_held;
   logic                  w_grant;

   cl_edge_det u_vs_edge (
      .CCLK  (CCLK),
      .RST   (RST),
      .iSIG  (iVSYNC),
      .oRISE (w_vs_rise),
      .oFALL (w_vs_fall)
   );

   cl_edge_det u_de_edge (
      .CCLK  (CCLK),
      .RST   (RST),
      .iSIG  (iDE),
      .oRISE (w_de_rise),
      .oFALL (w_de_fall)
   );

   // A line ending on the frame-ending edge still belongs to the ending frame.
   always_comb begin
      w_lines = oLINE_CNT;
      if (w_de_fall && (oLINE_CNT != '1))
         w_lines = oLINE_CNT + c_line_one;
   end

   assign w_frame_end = (r_state == CAPTURE) & iEN & w_vs_rise;
   assign w_held      = oRD_GNT & (oRD_BANK == other_bank(oMEM_SEL));
   assign w_grant     = iRD_REQ & oFRAME_RDY & ~oRD_GNT & ~w_frame_end;

   always_ff @(posedge CCLK) begin
      if (RST) begin
         r_state    <= IDLE;
         oMEM_SEL   <= BANK_A;
         oWR_EN     <= 1'b0;
         oFRAME_RDY <= 1'b0;
         oRD_GNT    <= 1'b0;
         oRD_BANK   <= BANK_A;
         oLINE_CNT  <= '0;
         oFRAME_CNT <= '0;
         oDROP_CNT  <= '0;
      end else begin
         oWR_EN <= (r_state == CAPTURE);

         if (!iEN) begin
            r_state   <= IDLE;
            oLINE_CNT <= '0;
         end else begin
            case (r_state)
               IDLE: r_state <= SYNC;
               SYNC: begin
                  oLINE_CNT <= '0;
                  if (w_vs_rise)
                     r_state <= CAPTURE;
               end
               CAPTURE: begin
                  if (w_vs_rise) begin
                     oLINE_CNT <= '0;
                     if (w_lines >= c_min_lines) begin
                        if (w_held) begin
                           if (oDROP_CNT != '1)
                              oDROP_CNT <= oDROP_CNT + c_cnt_one;
                        end else begin
                           oMEM_SEL   <= other_bank(oMEM_SEL);
                           oFRAME_RDY <= 1'b1;
                           oFRAME_CNT <= oFRAME_CNT + c_cnt_one;
                        end
                     end
                  end else begin
                     oLINE_CNT <= w_lines;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end

         // Grant is blocked on frame-end edges, so it never races the ready-flag set.
         if (w_grant) begin
            oRD_GNT    <= 1'b1;
            oRD_BANK   <= other_bank(oMEM_SEL);
            oFRAME_RDY <= 1'b0;
         end else if (iRD_DONE && oRD_GNT) begin
            oRD_GNT <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cl_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_cl_bank_sched : randomized self-checking bench with a frame-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cl_bank_sched;

   localparam int AW   = 11;
   localparam int CW   = 16;
   localparam int MINL = 16;

   logic          CCLK = 1'b0;
   logic          RST, iEN, iVSYNC, iDE, iRD_REQ, iRD_DONE;
   logic          oMEM_SEL, oWR_EN, oFRAME_RDY, oRD_GNT, oRD_BANK;
   logic [AW-1:0] oLINE_CNT;
   logic [CW-1:0] oFRAME_CNT, oDROP_CNT;
   logic [36:0]   w_obs;

   int n_tests = 0;
   int n_fail  = 0;

   // frame-level reference model
   logic          m_cap, m_sel, m_rdy, m_gnt, m_bank;
   logic [CW-1:0] m_fcnt, m_dcnt;
   int            m_lines;

   cl_bank_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MIN_LINES(MINL)) dut (
      .CCLK(CCLK), .RST(RST), .iEN(iEN), .iVSYNC(iVSYNC), .iDE(iDE),
      .iRD_REQ(iRD_REQ), .iRD_DONE(iRD_DONE), .oMEM_SEL(oMEM_SEL), .oWR_EN(oWR_EN),
      .oFRAME_RDY(oFRAME_RDY), .oRD_GNT(oRD_GNT), .oRD_BANK(oRD_BANK),
      .oLINE_CNT(oLINE_CNT), .oFRAME_CNT(oFRAME_CNT), .oDROP_CNT(oDROP_CNT)
   );

   always #5 CCLK = ~CCLK;

   assign w_obs = {oMEM_SEL, oWR_EN, oFRAME_RDY, oRD_GNT, oRD_BANK, oFRAME_CNT, oDROP_CNT};

   function automatic logic [36:0] exp_vec();
      return {m_sel, m_cap, m_rdy, m_gnt, m_bank, m_fcnt, m_dcnt};
   endfunction

   task automatic tick();
      @(posedge CCLK);
      #1;
   endtask

   task automatic model_reset();
      m_cap = 0; m_sel = 0; m_rdy = 0; m_gnt = 0; m_bank = 0;
      m_fcnt = '0; m_dcnt = '0; m_lines = 0;
   endtask

   task automatic model_frame_end();
      if (m_lines >= MINL) begin
         if (m_gnt && (m_bank == !m_sel)) begin
            if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
         end else begin
            m_sel  = !m_sel;
            m_rdy  = 1;
            m_fcnt = m_fcnt + 16'd1;
         end
      end
      m_lines = 0;
   endtask

   task automatic drive_lines(input int n);
      for (int i = 0; i < n; i++) begin
         iDE = 1'b1;
         repeat ($urandom_range(1, 4)) tick();
         iDE = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
         if (m_cap && m_lines < (1 << AW) - 1) m_lines++;
      end
      repeat (2) tick();
   endtask

   // Raises VSYNC; optional iRD_DONE lands on the same edge that evaluates the rise.
   task automatic vsync_edge(input bit with_done);
      repeat (3) tick();
      iVSYNC = 1'b1;
      tick();
      if (with_done) iRD_DONE = 1'b1;
      tick();
      iRD_DONE = 1'b0;
      if (iEN) begin
         if (!m_cap) m_cap = 1;
         else model_frame_end();
      end
      if (with_done) m_gnt = 0;
      repeat (2) tick();
      iVSYNC = 1'b0;
      tick();
   endtask

   task automatic rd_request();
      iRD_REQ = 1'b1;
      tick();
      if (m_rdy && !m_gnt) begin
         m_gnt = 1; m_bank = !m_sel; m_rdy = 0;
      end
      iRD_REQ = 1'b0;
      tick();
   endtask

   task automatic rd_done();
      iRD_DONE = 1'b1;
      tick();
      m_gnt = 0;
      iRD_DONE = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      RST = 1; iEN = 0; iVSYNC = 0; iDE = 0; iRD_REQ = 0; iRD_DONE = 0;
      repeat (3) tick();
      model_reset();
      n_tests++;
      if (w_obs !== exp_vec() || oLINE_CNT !== '0) begin
         n_fail++;
         $display("FAIL reset: got %h/%0d exp %h/0", w_obs, oLINE_CNT, exp_vec());
      end
      RST = 0;
      tick();
   endtask

   task automatic test_frames();
      iEN = 1;
      repeat (2) tick();
      vsync_edge(0);
      n_tests++;
      if (w_obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL first_vsync: got %h exp %h", w_obs, exp_vec());
      end
      for (int f = 1; f <= 3; f++) begin
         drive_lines(20);
         n_tests++;
         if (oLINE_CNT !== AW'(m_lines)) begin
            n_fail++;
            $display("FAIL frames_lines f%0d: got %0d exp %0d", f, oLINE_CNT, m_lines);
         end
         vsync_edge(0);
         n_tests++;
         if (w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL frames_end f%0d: got %h exp %h", f, w_obs, exp_vec());
         end
      end
      n_tests++;
      if (oFRAME_CNT !== 16'd3 || oMEM_SEL !== 1'b1 || oDROP_CNT !== 16'd0) begin
         n_fail++;
         $display("FAIL frames_total: got fc=%0d sel=%0d dc=%0d exp 3 1 0",
                  oFRAME_CNT, oMEM_SEL, oDROP_CNT);
      end
   endtask

   task automatic test_grant_hold();
      rd_request();
      n_tests++;
      if (w_obs !== exp_vec() || oRD_BANK !== 1'b0 || oRD_GNT !== 1'b1) begin
         n_fail++;
         $display("FAIL grant: got %h exp %h", w_obs, exp_vec());
      end
      for (int k = 0; k < 2; k++) begin
         drive_lines(18);
         vsync_edge(0);
      end
      n_tests++;
      if (w_obs !== exp_vec() || oDROP_CNT !== 16'd2 || oMEM_SEL !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_drop: got %h exp %h", w_obs, exp_vec());
      end
      rd_done();
      drive_lines(17);
      vsync_edge(0);
      n_tests++;
      if (w_obs !== exp_vec() || oMEM_SEL !== 1'b0) begin
         n_fail++;
         $display("FAIL after_release: got %h exp %h", w_obs, exp_vec());
      end
   endtask

   task automatic test_runt();
      drive_lines(10);
      n_tests++;
      if (oLINE_CNT !== AW'(10)) begin
         n_fail++;
         $display("FAIL runt_lines: got %0d exp 10", oLINE_CNT);
      end
      vsync_edge(0);
      n_tests++;
      if (w_obs !== exp_vec() || oLINE_CNT !== '0) begin
         n_fail++;
         $display("FAIL runt_end: got %h/%0d exp %h/0", w_obs, oLINE_CNT, exp_vec());
      end
   endtask

   task automatic test_done_coincide();
      rd_request();
      drive_lines(20);
      vsync_edge(1);
      n_tests++;
      if (w_obs !== exp_vec() || oRD_GNT !== 1'b0 || oDROP_CNT !== 16'd3) begin
         n_fail++;
         $display("FAIL done_coincide: got %h exp %h", w_obs, exp_vec());
      end
   endtask

   task automatic test_en_drop();
      drive_lines(5);
      iEN = 0;
      tick();
      m_cap = 0; m_lines = 0;
      repeat (2) tick();
      n_tests++;
      if (w_obs !== exp_vec() || oWR_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop: got %h exp %h", w_obs, exp_vec());
      end
      iEN = 1;
      tick();
      vsync_edge(0);
      n_tests++;
      if (w_obs !== exp_vec() || oLINE_CNT !== '0) begin
         n_fail++;
         $display("FAIL reenable: got %h/%0d exp %h/0", w_obs, oLINE_CNT, exp_vec());
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         drive_lines($urandom_range(10, 22));
         n_tests++;
         if (oLINE_CNT !== AW'(m_lines)) begin
            n_fail++;
            $display("FAIL rand_lines it%0d: got %0d exp %0d", it, oLINE_CNT, m_lines);
         end
         if ($urandom_range(0, 2) == 0) rd_request();
         if ($urandom_range(0, 3) == 0) rd_done();
         vsync_edge(m_gnt && ($urandom_range(0, 1) == 1));
         n_tests++;
         if (w_obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL rand_frame it%0d: got %h exp %h", it, w_obs, exp_vec());
         end
      end
   endtask

   task automatic test_reset_midgrant();
      if (m_gnt) rd_done();
      drive_lines(20);
      vsync_edge(0);
      rd_request();
      n_tests++;
      if (oRD_GNT !== 1'b1 || w_obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL pre_reset_grant: got %h exp %h", w_obs, exp_vec());
      end
      iDE = 1;
      repeat (2) tick();
      RST = 1;
      tick();
      model_reset();
      n_tests++;
      if (w_obs !== exp_vec() || oLINE_CNT !== '0) begin
         n_fail++;
         $display("FAIL reset_midgrant: got %h/%0d exp %h/0", w_obs, oLINE_CNT, exp_vec());
      end
      RST = 0; iDE = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_frames();
      test_grant_hold();
      test_runt();
      test_done_coincide();
      test_en_drop();
      test_random();
      test_reset_midgrant();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, limit 500000 ns");
      $fatal(1);
   end

endmodule

`default_nettype wire
